// File: rtl/switch_debouncer.sv
// Synchronises a raw switch vector into clk and debounces it as a whole vector,
// producing a clean registered value, a one-cycle change strobe and a settled flag.
module switch_debouncer #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             sw_changed,
    output logic             stable
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, SETTLE} state_t;

    state_t                              state, state_d;
    logic [CNT_W-1:0]                    cnt, cnt_d;
    logic [WIDTH-1:0]                    candidate, cand_d;
    logic [WIDTH-1:0]                    clean_d;
    logic                                changed_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
    logic [WIDTH-1:0]                    sw_sync;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sw_raw;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign sw_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STABLE;
            cnt        <= '0;
            candidate  <= '0;
            sw_clean   <= '0;
            sw_changed <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            candidate  <= cand_d;
            sw_clean   <= clean_d;
            sw_changed <= changed_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        cand_d    = candidate;
        clean_d   = sw_clean;
        changed_d = 1'b0;
        case (state)
            STABLE: begin
                cnt_d = '0;
                if (sw_sync != sw_clean) begin
                    cand_d  = sw_sync;
                    cnt_d   = CNT_W'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Bounce-back beats a new candidate, which beats acceptance.
                if (sw_sync == sw_clean) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (sw_sync != candidate) begin
                    cand_d = sw_sync;
                    cnt_d  = CNT_W'(1);
                end else if (cnt == CNT_MAX) begin
                    clean_d   = candidate;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = STABLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
    end

    assign stable = (state == STABLE);
endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: accepted switch changes push (value, due cycle); the
// negedge monitor pops on every sw_changed pulse and compares.
module tb_switch_debouncer;
    localparam int LAT = 6;  // SYNC_STAGES + DEBOUNCE_CYCLES for this build

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw_raw;
    logic [1:0] sw_clean;
    logic       sw_changed;
    logic       stable;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [1:0] exp_q[$];
    int         cyc_q[$];
    logic [1:0] last_clean = 2'b00;

    switch_debouncer #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_changed (sw_changed),
        .stable     (stable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a raw value; if it is expected to be accepted, schedule its update.
    task automatic put(input logic [1:0] v, input bit accept);
        sw_raw = v;
        if (accept) begin
            exp_q.push_back(v);
            cyc_q.push_back(cyc + LAT);
        end
    endtask

    always @(negedge clk) begin
        if (sw_changed) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", sw_changed, 1'b0);
            end else begin
                check("upd_value", sw_clean, exp_q.pop_front());
                check("upd_cycle", cyc, cyc_q.pop_front());
            end
        end
        if (!reset && sw_clean !== last_clean)
            check("clean_needs_strobe", sw_changed, 1'b1);
        last_clean = sw_clean;
    end

    initial begin
        logic [1:0] seq [4];
        seq = '{2'b10, 2'b11, 2'b10, 2'b01};

        // 1: reset with raw=11
        reset = 1'b1;
        sw_raw = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check("rst_clean", sw_clean, 2'b00);
            check("rst_changed", sw_changed, 1'b0);
            check("rst_stable", stable, 1'b1);
        end
        reset = 1'b0;
        sw_raw = 2'b00;
        tick(3);

        // 2: single clean change
        put(2'b10, 1);
        tick(10);
        check("t2_clean", sw_clean, 2'b10);
        put(2'b00, 1);
        tick(10);
        check("t2_back", sw_clean, 2'b00);

        // 3: one-cycle bounces, then a DEBOUNCE-1 hold, then a DEBOUNCE hold
        put(2'b10, 0); tick(1);
        put(2'b00, 0); tick(1);
        put(2'b10, 0); tick(1);
        put(2'b00, 0); tick(8);
        check("t3_bounce_clean", sw_clean, 2'b00);
        check("t3_bounce_stable", stable, 1'b1);
        put(2'b10, 0); tick(3);
        put(2'b00, 0); tick(8);
        check("t3_short_clean", sw_clean, 2'b00);
        put(2'b10, 1); tick(4);
        put(2'b00, 1); tick(12);
        check("t3_b2b_clean", sw_clean, 2'b00);

        // 4: third value restarts the candidate
        put(2'b10, 1); tick(8);
        put(2'b11, 0); tick(2);
        put(2'b01, 1); tick(3);
        check("t4_settling", stable, 1'b0);
        tick(7);
        check("t4_clean", sw_clean, 2'b01);

        // 5: sequence of held codes, including a two-bit flip 10->01
        foreach (seq[i]) begin
            put(seq[i], 1);
            tick(8);
            check("t5_clean", sw_clean, seq[i]);
        end

        // 6: reset while settling at cnt=2
        put(2'b11, 0); tick(4);
        check("t6_settling", stable, 1'b0);
        reset = 1'b1;
        tick(1);
        check("t6_clean", sw_clean, 2'b00);
        check("t6_stable", stable, 1'b1);
        check("t6_changed", sw_changed, 1'b0);
        sw_raw = 2'b00;
        tick(1);
        reset = 1'b0;
        tick(10);
        check("t6_after_clean", sw_clean, 2'b00);
        check("t6_after_stable", stable, 1'b1);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
